// File: rtl/array_7_arb_if.sv
// Requester-side port of the SRAM arbiter: request handshake plus the routed read response.
// The client drives the master side; the arbiter takes the slave side.
interface array_7_arb_if #(
  parameter int AW = 4,
  parameter int DW = 24,
  parameter int MW = 2
);
  logic          valid;
  logic          ready;
  logic          write;
  logic [AW-1:0] addr;
  logic [MW-1:0] mask;
  logic [DW-1:0] wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;

  modport master (
    output valid, write, addr, mask, wdata,
    input  ready, resp_valid, resp_rdata
  );

  modport slave (
    input  valid, write, addr, mask, wdata,
    output ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/array_7_arb.sv
// Clears the 16x24 masked SRAM after reset, then round-robins its single RW port
// between two requesters and steers each read result back to its issuer.
//
// state  | meaning
// S_INIT | sweeping zeros into every entry, requesters held off
// S_RUN  | array cleared, arbitration active
module array_7_arb #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 24,
  parameter int MW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  array_7_arb_if.slave  req0,
  array_7_arb_if.slave  req1,
  output logic          init_done,
  output logic          mem_en,
  output logic          mem_wmode,
  output logic [AW-1:0] mem_addr,
  output logic [MW-1:0] mem_wmask,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] init_cnt;
  logic          prio;        // 0 favours req0 under contention, 1 favours req1
  logic          rd_pend0, rd_pend1;
  logic          grant0, grant1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
      prio     <= 1'b0;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == S_INIT) ? init_cnt + 1'b1 : '0;
      // Under contention the loser gets priority next time: winner 0 -> point at 1.
      if (req0.valid && req1.valid && (grant0 || grant1))
        prio <= grant0;
      rd_pend0 <= grant0 && !req0.write;
      rd_pend1 <= grant1 && !req1.write;
    end
  end

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        S_INIT: begin
          mem_en    = 1'b1;
          mem_wmode = 1'b1;
          mem_wmask = '1;
          mem_addr  = init_cnt;
          if (init_cnt == AW'(DEPTH - 1))
            state_nxt = S_RUN;
        end
        S_RUN: begin
          if (req0.valid && (!req1.valid || !prio))
            grant0 = 1'b1;
          else if (req1.valid)
            grant1 = 1'b1;

          if (grant0) begin
            mem_en    = 1'b1;
            mem_wmode = req0.write;
            mem_addr  = req0.addr;
            mem_wmask = req0.write ? req0.mask : '0;
            mem_wdata = req0.wdata;
          end else if (grant1) begin
            mem_en    = 1'b1;
            mem_wmode = req1.write;
            mem_addr  = req1.addr;
            mem_wmask = req1.write ? req1.mask : '0;
            mem_wdata = req1.wdata;
          end
        end
        default: state_nxt = S_INIT;
      endcase
    end
  end

  // All outputs read zero while reset is held, including the registered ones.
  assign req0.ready      = grant0;
  assign req1.ready      = grant1;
  assign req0.resp_valid = rd_pend0 && !reset;
  assign req1.resp_valid = rd_pend1 && !reset;
  assign req0.resp_rdata = req0.resp_valid ? mem_rdata : '0;
  assign req1.resp_rdata = req1.resp_valid ? mem_rdata : '0;
  assign init_done       = (state == S_RUN) && !reset;

endmodule
